inmp441_mic_sdo_emulator: RTL

//  Responder (microphone) end of the INMP441-style mic serial link: receives cs/sck from the
//  mic SPI receiver (master) and serializes 16-bit PCM samples onto sdo.

---
 rtl/inmp441_mic_sdo_emulator.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/inmp441_mic_sdo_emulator.sv
// Microphone end of the INMP441-style serial link: synchronizes the master's cs/sck into clk
// and shifts one buffered 16-bit PCM sample per cs-low frame out on sdo, MSB first.
module inmp441_mic_sdo_emulator #(
  parameter int DATA_W      = 16,
  parameter int FRAME_BITS  = 32,
  parameter int LEAD_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sck,
  output logic              sdo,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              frame_done,
  output logic              underrun,
  output logic              frame_error
);

  localparam int PAD_BITS = FRAME_BITS - LEAD_BITS - DATA_W;
  localparam int SLOT_W   = $clog2(FRAME_BITS + 1);

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } state_t;

  // Synchronizers idle high so that leaving reset never produces a false cs or sck fall.
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic                   cs_d;
  logic                   sck_d;
  logic                   cs_fall_r;
  logic                   cs_rise_r;
  logic                   sck_fall_r;

  state_t                 state;
  state_t                 state_next;
  logic                   start_frame;
  logic                   end_frame;
  logic                   advance;

  logic [DATA_W-1:0]      buf_data;
  logic                   buf_full;
  logic [DATA_W-1:0]      last_sample;
  logic [FRAME_BITS-1:0]  shift;
  logic [SLOT_W-1:0]      slot;
  logic                   accept;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_W-1:0] s);
    return FRAME_BITS'(s) << PAD_BITS;
  endfunction

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync    <= '1;
      sck_sync   <= '1;
      cs_d       <= 1'b1;
      sck_d      <= 1'b1;
      cs_fall_r  <= 1'b0;
      cs_rise_r  <= 1'b0;
      sck_fall_r <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_d       <= cs_sync[SYNC_STAGES-1];
      sck_d      <= sck_sync[SYNC_STAGES-1];
      cs_fall_r  <= cs_d & ~cs_sync[SYNC_STAGES-1];
      cs_rise_r  <= ~cs_d & cs_sync[SYNC_STAGES-1];
      sck_fall_r <= sck_d & ~sck_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    advance     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall_r) begin
          start_frame = 1'b1;
          state_next  = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (cs_rise_r) begin
          end_frame  = 1'b1;
          state_next = ST_IDLE;
        end else if (sck_fall_r && !cs_d) begin
          // cs_d is the synced cs level aligned with the registered edge pulses.
          advance = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign sample_ready = ~buf_full;
  assign accept       = sample_valid & ~buf_full;

  // NOTE: the sample buffer and shift register are reset along with the control state,
  // so a reset mid-frame can never leak stale data onto sdo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_data    <= '0;
      buf_full    <= 1'b0;
      last_sample <= '0;
      shift       <= '0;
      slot        <= '0;
      sdo         <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
      frame_error <= 1'b0;

      if (start_frame) begin
        slot <= '0;
        sdo  <= 1'b0;
        if (buf_full) begin
          shift       <= build_frame(buf_data);
          last_sample <= buf_data;
        end else begin
          shift    <= build_frame(last_sample);
          underrun <= 1'b1;
        end
      end else if (end_frame) begin
        sdo         <= 1'b0;
        frame_done  <= 1'b1;
        frame_error <= (slot != SLOT_W'(FRAME_BITS));
      end else if (advance) begin
        // Once the shift register has drained it holds zeros, so late falls drive sdo low.
        sdo   <= shift[FRAME_BITS-1];
        shift <= shift << 1;
        if (slot != SLOT_W'(FRAME_BITS)) begin
          slot <= slot + 1'b1;
        end
      end

      // A sample accepted on the frame-start cycle lands in the buffer for the next frame.
      if (accept) begin
        buf_data <= sample_data;
        buf_full <= 1'b1;
      end else if (start_frame) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule
